// File: rtl/sram_like_pkg.sv
// -----------------------------------------------------------------------------
// sram_like_pkg
// Shared definitions for the SRAM-like slave: transfer-size encodings, the
// response-queue depth, the stall-LFSR seed, the queued response record and
// the byte-lane decode helper.
// -----------------------------------------------------------------------------
package sram_like_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  localparam int          QUEUE_DEPTH = 2;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  // One queued response: cycles left before it may be presented, plus the
  // read word captured at acceptance (zero for writes and misaligned reads).
  typedef struct packed {
    logic [2:0]  cnt;
    logic [31:0] data;
  } resp_entry_t;

  typedef struct packed {
    logic       misaligned;
    logic [3:0] be;
  } lane_sel_t;

  // Byte enables and alignment status for one request.
  function automatic lane_sel_t decode_lanes(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    lane_sel_t sel;
    sel.misaligned = 1'b0;
    sel.be         = 4'b0000;
    case (size)
      SZ_BYTE: sel.be = 4'b0001 << addr_lo;
      SZ_HALF: begin
        sel.misaligned = addr_lo[0];
        sel.be         = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        sel.misaligned = (addr_lo != 2'b00);
        sel.be         = 4'b1111;
      end
      default: sel.misaligned = 1'b1;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sram_resp_queue.sv
// -----------------------------------------------------------------------------
// sram_resp_queue
// Two-entry in-order response queue. Each pushed entry is loaded with a
// countdown of LATENCY-1; the head entry is presented (o_data_ok) once its
// countdown reaches zero and leaves the queue on that same edge.
//
// Ports
//   clk          in   clock, rising edge
//   resetn       in   asynchronous active-low reset, empties the queue
//   i_push       in   accept a new response this cycle (never while full)
//   i_push_data  in   read word to return for this response
//   o_count      out  registered occupancy (0..2)
//   o_data_ok    out  head response completes this cycle
//   o_rdata      out  head data while o_data_ok, otherwise last returned word
// -----------------------------------------------------------------------------
module sram_resp_queue
  import sram_like_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_push,
  input  logic [31:0] i_push_data,
  output logic [1:0]  o_count,
  output logic        o_data_ok,
  output logic [31:0] o_rdata
);

  localparam logic [2:0] LOAD_CNT = 3'(LATENCY - 1);

  resp_entry_t r_slot [QUEUE_DEPTH];
  logic [1:0]  r_count;
  logic [31:0] r_last;

  resp_entry_t w_slot_nxt [QUEUE_DEPTH];
  logic [1:0]  w_count_nxt;
  logic        w_pop;

  // Slot 0 is always the head; later entries shift down when it leaves.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    w_pop       = (r_count != 2'd0) && (r_slot[0].cnt == 3'd0);
    w_count_nxt = r_count;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      w_slot_nxt[i] = r_slot[i];
      if (r_slot[i].cnt != 3'd0) w_slot_nxt[i].cnt = r_slot[i].cnt - 3'd1;
    end
    if (w_pop) begin
      w_slot_nxt[0] = w_slot_nxt[1];
      w_count_nxt   = r_count - 2'd1;
    end
    // After a pop the first free slot index equals the remaining occupancy.
    if (i_push) begin
      w_slot_nxt[w_count_nxt[0]] = '{cnt: LOAD_CNT, data: i_push_data};
      w_count_nxt                = w_count_nxt + 2'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= 2'd0;
      r_last  <= 32'h0;
      for (int i = 0; i < QUEUE_DEPTH; i++) r_slot[i] <= '0;
    end else begin
      r_count <= w_count_nxt;
      for (int i = 0; i < QUEUE_DEPTH; i++) r_slot[i] <= w_slot_nxt[i];
      if (w_pop) r_last <= r_slot[0].data;
    end
  end

  assign o_count   = r_count;
  assign o_data_ok = w_pop;
  assign o_rdata   = w_pop ? r_slot[0].data : r_last;

endmodule

// File: rtl/sram_like_slave.sv
// -----------------------------------------------------------------------------
// sram_like_slave
// SRAM-like bus slave backed by a 2^ADDR_W x 32-bit array. Requests are
// accepted while fewer than two responses are outstanding; each response
// returns exactly LATENCY cycles after acceptance, in acceptance order.
// Misaligned requests are answered but never write and read back zero.
//
// Optional feature: define SRAM_SLAVE_RANDOM_STALL_EN to gate addr_ok with
// bit 0 of a free-running 16-bit Fibonacci LFSR (pseudo-random stalls).
//
// Ports
//   clk      in   clock, rising edge
//   resetn   in   asynchronous active-low reset
//   req      in   request valid
//   wr       in   1 = write, 0 = read
//   size     in   0 byte, 1 halfword, 2 word, 3 reserved
//   addr     in   byte address (bits above ADDR_W+1 ignored)
//   wdata    in   write data, lane-replicated by the initiator
//   addr_ok  out  request accepted when req & addr_ok at the rising edge
//   data_ok  out  one response completes this cycle
//   rdata    out  read word, valid with data_ok on reads; held otherwise
// -----------------------------------------------------------------------------
module sram_like_slave
  import sram_like_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  logic [31:0]       r_mem [2**ADDR_W];

  logic [ADDR_W-1:0] w_index;
  lane_sel_t         w_lanes;
  logic              w_accept;
  logic [31:0]       w_rd_data;
  logic [1:0]        w_outstanding;
  logic              w_room;
  logic              w_unused_addr;

  assign w_index       = addr[ADDR_W+1:2];
  assign w_unused_addr = ^addr[31:ADDR_W+2];
  assign w_lanes       = decode_lanes(size, addr[1:0]);

  // Room depends only on the registered occupancy, never on req.
  // Gating with resetn keeps addr_ok low throughout reset and lets it rise
  // as soon as reset is released.
  assign w_room = resetn && (w_outstanding < 2'(QUEUE_DEPTH));

`ifdef SRAM_SLAVE_RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  // Taps 16,14,13,11 in right-shift form: bits 0,2,3,5 feed bit 15.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_lfsr <= LFSR_SEED;
    else         r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  assign addr_ok = w_room && r_lfsr[0];
`else
  assign addr_ok = w_room;
`endif

  assign w_accept = req && addr_ok;

  // NOTE: the storage array is deliberately left without a reset; only control state is reset.
  always_ff @(posedge clk) begin
    if (w_accept && wr && !w_lanes.misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lanes.be[i]) r_mem[w_index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Earlier accepted writes have already landed in the array, so sampling
  // it combinationally at acceptance gives read-after-write ordering.
  assign w_rd_data = (wr || w_lanes.misaligned) ? 32'h0 : r_mem[w_index];

  sram_resp_queue #(
    .LATENCY (LATENCY)
  ) u_resp_queue (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_accept),
    .i_push_data (w_rd_data),
    .o_count     (w_outstanding),
    .o_data_ok   (data_ok),
    .o_rdata     (rdata)
  );

endmodule

// File: tb/tb_sram_like_slave.sv
// -----------------------------------------------------------------------------
// tb_sram_like_slave
// Directed bench for sram_like_slave: one instance with LATENCY=1 and one
// with LATENCY=3 share clock and reset. Inputs are driven and outputs
// sampled on the falling edge. A randomized phase compares the LATENCY=1
// instance against a small reference memory and an in-order scoreboard.
// -----------------------------------------------------------------------------
module tb_sram_like_slave;
  import sram_like_pkg::*;

  logic        clk;
  logic        resetn;

  logic        r1_req, r1_wr;
  logic [1:0]  r1_size;
  logic [31:0] r1_addr, r1_wdata;
  logic        w1_addr_ok, w1_data_ok;
  logic [31:0] w1_rdata;

  logic        r3_req, r3_wr;
  logic [1:0]  r3_size;
  logic [31:0] r3_addr, r3_wdata;
  logic        w3_addr_ok, w3_data_ok;
  logic [31:0] w3_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  sram_like_slave #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .req(r1_req), .wr(r1_wr), .size(r1_size),
    .addr(r1_addr), .wdata(r1_wdata), .addr_ok(w1_addr_ok),
    .data_ok(w1_data_ok), .rdata(w1_rdata)
  );

  sram_like_slave #(.ADDR_W(10), .LATENCY(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .req(r3_req), .wr(r3_wr), .size(r3_size),
    .addr(r3_addr), .wdata(r3_wdata), .addr_ok(w3_addr_ok),
    .data_ok(w3_data_ok), .rdata(w3_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  // One isolated transfer on the LATENCY=1 instance: drive at a falling edge,
  // expect the response one cycle later, then leave one idle cycle.
  task automatic issue1(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input string tag);
    r1_req = 1'b1; r1_wr = w; r1_size = sz; r1_addr = a; r1_wdata = d;
    @(negedge clk);
    r1_req = 1'b0;
    check({tag, "_dok"}, 32'(w1_data_ok), 32'd1);
    if (!w) check({tag, "_rdata"}, w1_rdata, exp);
    @(negedge clk);
  endtask

  // One isolated transfer on the LATENCY=3 instance; checks response latency.
  task automatic issue3(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int k;
    r3_req = 1'b1; r3_wr = w; r3_size = sz; r3_addr = a; r3_wdata = d;
    @(negedge clk);
    r3_req = 1'b0;
    k = 1;
    while (!w3_data_ok && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'd3);
    @(negedge clk);
  endtask

  // Back-to-back read timeline for LATENCY=3, one entry per falling edge.
  logic        t_req  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] t_addr [9] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0};
  logic        t_aok  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        t_dok  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] t_rd   [9] = '{32'h0, 32'h0, 32'h0, 32'hA0A0_A0A0, 32'hB1B1_B1B1,
                              32'h0, 32'h0, 32'hC2C2_C2C2, 32'hC2C2_C2C2};

  // Reference model for the randomized phase.
  typedef struct {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;

  logic [31:0] mdl_mem [16];
  exp_t        sb [$];

  task automatic take_response();
    exp_t e;
    if (w1_data_ok) begin
      if (sb.size() == 0) begin
        check("rnd_unexpected_dok", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.is_rd) check("rnd_rdata", w1_rdata, e.data);
      end
    end
  endtask

  initial begin
    int n_acc, n_stall, cyc, n_dok;
    logic [31:0] rnd, a, d;
    logic        w, go, mis;
    logic [1:0]  sz, lane;
    logic [3:0]  idx, be;
    exp_t        e;

    resetn = 1'b0;
    r1_req = 1'b0; r1_wr = 1'b0; r1_size = 2'd0; r1_addr = 32'h0; r1_wdata = 32'h0;
    r3_req = 1'b0; r3_wr = 1'b0; r3_size = 2'd0; r3_addr = 32'h0; r3_wdata = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_addr_ok1", 32'(w1_addr_ok), 32'd0);
    check("rst_data_ok1", 32'(w1_data_ok), 32'd0);
    check("rst_rdata1", w1_rdata, 32'h0);
    check("rst_addr_ok3", 32'(w3_addr_ok), 32'd0);
    check("rst_data_ok3", 32'(w3_data_ok), 32'd0);
    resetn = 1'b1;
    #1;
    check("rel_addr_ok1", 32'(w1_addr_ok), 32'd1);
    check("rel_addr_ok3", 32'(w3_addr_ok), 32'd1);
    @(negedge clk);

`ifndef SRAM_SLAVE_RANDOM_STALL_EN
    // Write then read the same word on consecutive cycles.
    r1_req = 1'b1; r1_wr = 1'b1; r1_size = SZ_WORD; r1_addr = 32'h10; r1_wdata = 32'h1234_5678;
    @(negedge clk);
    check("b2b_wr_dok", 32'(w1_data_ok), 32'd1);
    r1_wr = 1'b0; r1_wdata = 32'h0;
    @(negedge clk);
    check("b2b_rd_dok", 32'(w1_data_ok), 32'd1);
    check("b2b_rd_rdata", w1_rdata, 32'h1234_5678);
    check("b2b_addr_ok", 32'(w1_addr_ok), 32'd1);
    r1_req = 1'b0;
    @(negedge clk);
    check("idle_dok", 32'(w1_data_ok), 32'd0);
    check("idle_rdata_hold", w1_rdata, 32'h1234_5678);

    // Lane merging, misalignment and aliasing.
    issue1(1'b1, SZ_WORD, 32'h10,        32'h1111_1111, 32'h0,         "wr_init");
    issue1(1'b1, SZ_BYTE, 32'h13,        32'hAAAA_AAAA, 32'h0,         "wr_byte3");
    issue1(1'b0, SZ_WORD, 32'h10,        32'h0,         32'hAA11_1111, "rd_byte_merge");
    issue1(1'b0, SZ_HALF, 32'h12,        32'h0,         32'hAA11_1111, "rd_half_full");
    issue1(1'b0, SZ_WORD, 32'h12,        32'h0,         32'h0,         "rd_misal_word");
    issue1(1'b1, SZ_WORD, 32'h20,        32'hCAFE_F00D, 32'h0,         "wr_0x20");
    issue1(1'b1, SZ_HALF, 32'h21,        32'h5555_5555, 32'h0,         "wr_misal_half");
    issue1(1'b0, SZ_WORD, 32'h20,        32'h0,         32'hCAFE_F00D, "rd_after_misal");
    issue1(1'b0, SZ_RSVD, 32'h20,        32'h0,         32'h0,         "rd_rsvd");
    issue1(1'b1, SZ_HALF, 32'h22,        32'hBEEF_BEEF, 32'h0,         "wr_half_hi");
    issue1(1'b1, SZ_RSVD, 32'h20,        32'hFFFF_FFFF, 32'h0,         "wr_rsvd");
    issue1(1'b0, SZ_WORD, 32'h1000_0020, 32'h0,         32'hBEEF_F00D, "rd_alias");

    // LATENCY=3: preload, then three back-to-back reads.
    issue3(1'b1, SZ_WORD, 32'h0, 32'hA0A0_A0A0, "l3_wr0");
    issue3(1'b1, SZ_WORD, 32'h4, 32'hB1B1_B1B1, "l3_wr4");
    issue3(1'b1, SZ_WORD, 32'h8, 32'hC2C2_C2C2, "l3_wr8");
    r3_wr = 1'b0; r3_size = SZ_WORD;
    for (int s = 0; s < 9; s++) begin
      check($sformatf("l3_aok_%0d", s), 32'(w3_addr_ok), 32'(t_aok[s]));
      check($sformatf("l3_dok_%0d", s), 32'(w3_data_ok), 32'(t_dok[s]));
      if (t_dok[s] || s == 8) check($sformatf("l3_rdata_%0d", s), w3_rdata, t_rd[s]);
      r3_req  = t_req[s];
      r3_addr = t_addr[s];
      @(negedge clk);
    end

    // Reset with two reads outstanding.
    r3_req = 1'b1; r3_wr = 1'b0; r3_size = SZ_WORD; r3_addr = 32'h0;
    @(negedge clk);
    r3_addr = 32'h4;
    @(negedge clk);
    r3_req = 1'b0;
    check("mid_two_outstanding", 32'(w3_addr_ok), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_dok", 32'(w3_data_ok), 32'd0);
    check("mid_rst_rdata", w3_rdata, 32'h0);
    check("mid_rst_aok", 32'(w3_addr_ok), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    check("mid_rel_aok", 32'(w3_addr_ok), 32'd1);
    n_dok = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (w3_data_ok) n_dok++;
    end
    check("mid_no_stale_dok", 32'(n_dok), 32'd0);
`endif

    // Randomized traffic against the reference model (LATENCY=1 instance).
    n_acc = 0; n_stall = 0; cyc = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      take_response();
      if (!w1_addr_ok) n_stall++;
      go = (n_acc < 16) || ($urandom_range(0, 3) != 0);
      if (go) begin
        if (n_acc < 16) begin
          w = 1'b1; sz = SZ_WORD; idx = 4'(n_acc); lane = 2'd0;
        end else begin
          w = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
          idx = 4'($urandom_range(0, 15)); lane = 2'($urandom_range(0, 3));
        end
        rnd = $urandom();
        a = (rnd & 32'hFFFF_F000) | {26'b0, idx, lane};
        d = $urandom();
        r1_req = 1'b1; r1_wr = w; r1_size = sz; r1_addr = a; r1_wdata = d;
        if (w1_addr_ok) begin
          mis = (sz == 2'd3) || (sz == 2'd1 && lane[0]) || (sz == 2'd2 && lane != 2'd0);
          case (sz)
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
          endcase
          e.is_rd = !w;
          e.data  = (!w && !mis) ? mdl_mem[idx] : 32'h0;
          if (w && !mis) begin
            for (int i = 0; i < 4; i++) begin
              if (be[i]) mdl_mem[idx][8*i +: 8] = d[8*i +: 8];
            end
          end
          sb.push_back(e);
          n_acc++;
        end
      end else begin
        r1_req = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    r1_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      take_response();
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("rnd_accepted", 32'(n_acc), 32'd1000);
    check("rnd_drained", 32'(sb.size()), 32'd0);
`ifdef SRAM_SLAVE_RANDOM_STALL_EN
    check("rnd_stall_seen", 32'(n_stall > 0), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
